// File: rtl/hpdl_cmd_parser.sv
// Byte-stream command parser feeding the 16-place HPDL display buffer.
// Ports: CLK/RST_N, rx_valid/rx_data in; w_en/w_addr/w_data, cursor, busy, overflow out.
module hpdl_cmd_parser #(
  parameter bit         WRAP     = 1'b1,
  parameter bit         UPCASE   = 1'b1,
  parameter logic [6:0] SUB_CHAR = 7'h3F
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       w_en,
  output logic [3:0] w_addr,
  output logic [6:0] w_data,
  output logic [3:0] cursor,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    ESC_POS,
    CLEAR
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_v_q, pend_v_d;
  logic       w_en_q, w_en_d;
  logic [3:0] w_addr_q, w_addr_d;
  logic [6:0] w_data_q, w_data_d;
  logic [3:0] cursor_q, cursor_d;
  logic       busy_q, busy_d;
  logic       ovf_q, ovf_d;

  logic       byte_v;
  logic [7:0] byte_b;
  logic [7:0] upc;
  logic [6:0] chr;
  logic [3:0] nxt;
  logic       is_ctrl;
  logic       is_print;
  logic       is_lower;
  logic       clr_go;

  // Pending byte always wins over the live strobe.
  assign byte_v = (state_q != CLEAR) && (pend_v_q || rx_valid);
  assign byte_b = pend_v_q ? pend_q : rx_data;

  assign is_ctrl  = byte_b < 8'h20;
  assign is_print = (byte_b >= 8'h20) && (byte_b <= 8'h5F);
  assign is_lower = (byte_b >= 8'h61) && (byte_b <= 8'h7A);
  assign upc      = byte_b - 8'h20;

  always_comb begin
    chr = SUB_CHAR;
    if (is_print) begin
      chr = byte_b[6:0];
    end else if (is_lower && UPCASE) begin
      chr = upc[6:0];
    end
  end

  always_comb begin
    nxt = cursor_q + 4'd1;
    if (cursor_q == 4'hF) begin
      nxt = WRAP ? 4'h0 : 4'hF;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    cursor_d = cursor_q;
    busy_d   = 1'b0;
    ovf_d    = ovf_q;
    clr_go   = 1'b0;
    if (state_q == CLEAR) begin
      if (rx_valid) begin
        if (pend_v_q) begin
          ovf_d = 1'b1;
        end else begin
          pend_d   = rx_data;
          pend_v_d = 1'b1;
        end
      end
      // cnt wraps to 0 once place 15 has been blanked
      if (cnt_q != 4'd0) begin
        busy_d   = 1'b1;
        w_en_d   = 1'b1;
        w_addr_d = cnt_q;
        w_data_d = 7'h20;
        cnt_d    = cnt_q + 4'd1;
      end else begin
        cursor_d = 4'd0;
        state_d  = IDLE;
      end
    end else begin
      if (pend_v_q) begin
        pend_v_d = rx_valid;
        if (rx_valid) begin
          pend_d = rx_data;
        end
      end
      if (byte_v) begin
        unique case (state_q)
          IDLE: begin
            unique case (1'b1)
              is_ctrl: begin
                case (byte_b)
                  8'h0D: cursor_d = 4'd0;
                  8'h08: begin
                    if (cursor_q != 4'd0) begin
                      cursor_d = cursor_q - 4'd1;
                      w_en_d   = 1'b1;
                      w_addr_d = cursor_q - 4'd1;
                      w_data_d = 7'h20;
                    end
                  end
                  8'h0C: clr_go = 1'b1;
                  8'h1B: state_d = ESC;
                  default: ;
                endcase
              end
              default: begin
                w_en_d   = 1'b1;
                w_addr_d = cursor_q;
                w_data_d = chr;
                cursor_d = nxt;
              end
            endcase
          end
          ESC: begin
            state_d = IDLE;
            if (byte_b == 8'h50) begin
              state_d = ESC_POS;
            end else if (byte_b == 8'h43) begin
              clr_go = 1'b1;
            end
          end
          ESC_POS: begin
            state_d = IDLE;
            if (byte_b[7:4] == 4'h3) begin
              cursor_d = byte_b[3:0];
            end
          end
          default: ;
        endcase
      end
      // First blank write happens on the entry edge itself.
      if (clr_go) begin
        state_d  = CLEAR;
        cnt_d    = 4'd1;
        busy_d   = 1'b1;
        w_en_d   = 1'b1;
        w_addr_d = 4'd0;
        w_data_d = 7'h20;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      pend_q   <= 8'h00;
      pend_v_q <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= 4'd0;
      w_data_q <= 7'h20;
      cursor_q <= 4'd0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      cursor_q <= cursor_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign w_en     = w_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign cursor   = cursor_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
